// File: rtl/mem_copy_dma.sv
// mem_copy_dma -- block-copy initiator for a single-ported word memory.
//
// Copies `len` consecutive words from `src_addr` to `dst_addr`. Each word
// takes one read cycle (RD) and then one write cycle (WR), because the port
// cannot read and write in the same cycle. The copy runs strictly in
// ascending address order. If the ranges overlap with dst > src, the data
// is replicated. Addresses wrap modulo 2^ADDR_W.
//
// Optional feature: define DMA_CHECKSUM_EN to add a `checksum` output. It is
// the running sum (mod 2^DATA_W) of every word read during the transfer.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   start                   request; only sampled while idle
//   src_addr, dst_addr, len transfer descriptor, captured on an accepted start
//   abort                   stops the transfer after the current access
//   busy                    high from the accepted start until back in idle
//   done / aborted          one-cycle completion pulses
//   mem_addr, mem_re,
//   mem_we, mem_wrt_data    memory request side, all driven straight from flops
//   mem_rd_data             memory read data, captured at the end of RD
//   checksum                (DMA_CHECKSUM_EN only) running sum of words read
module mem_copy_dma #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wrt_data,
  input  logic [DATA_W-1:0] mem_rd_data
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  // One-hot states: each memory strobe is a bare state flop, so it cannot
  // glitch and it drops the instant reset is asserted.
  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_RD   = 4'b0010;
  localparam logic [3:0] S_WR   = 4'b0100;
  localparam logic [3:0] S_FIN  = 4'b1000;

  logic [3:0]        state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q, addr_nxt;
  logic [LEN_W-1:0]  len_q, cnt, cnt_inc;
  logic [DATA_W-1:0] rbuf;
  logic              fin_abort;
  logic              accept, last;

  assign accept  = (state == S_IDLE) && start;
  assign cnt_inc = cnt + LEN_W'(1);
  assign last    = (cnt_inc == len_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (len == '0) ? S_FIN : S_RD;
      S_RD:   state_nxt = abort ? S_FIN : S_WR;
      S_WR:   state_nxt = (abort || last) ? S_FIN : S_RD;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: this computes the address for the next cycle, so that
  // mem_addr is registered. The address is left unchanged on every path
  // that does not lead into RD or WR, so it holds its last value when idle.
  always_comb begin
    addr_nxt = mem_addr;
    case (state)
      S_IDLE: if (start && len != '0) addr_nxt = src_addr;
      S_RD:   if (!abort) addr_nxt = dst_q + ADDR_W'(cnt);
      S_WR:   if (!abort && !last) addr_nxt = src_q + ADDR_W'(cnt_inc);
      default: addr_nxt = mem_addr;
    endcase
  end

  // Datapath: descriptor, word counter, read buffer, abort flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      cnt       <= '0;
      rbuf      <= '0;
      fin_abort <= 1'b0;
    end else begin
      mem_addr <= addr_nxt;
      if (accept) begin
        src_q     <= src_addr;
        dst_q     <= dst_addr;
        len_q     <= len;
        cnt       <= '0;
        fin_abort <= 1'b0;
      end
      if (state == S_RD) rbuf <= mem_rd_data;
      if (state == S_WR) cnt  <= cnt_inc;
      // Remember why FIN was entered, so it can raise the right pulse.
      if ((state == S_RD || state == S_WR) && abort) fin_abort <= 1'b1;
    end
  end

`ifdef DMA_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              checksum <= '0;
    else if (accept)         checksum <= '0;
    else if (state == S_RD)  checksum <= checksum + mem_rd_data;
  end
`endif

  assign mem_re       = state[1];
  assign mem_we       = state[2];
  assign mem_wrt_data = rbuf;
  assign busy         = ~state[0];
  assign done         = state[3] & ~fin_abort;
  assign aborted      = state[3] &  fin_abort;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Testbench for mem_copy_dma. It contains a word memory that the DUT drives,
// and a reference model of that memory.
//
// For each transfer, run_copy first works out the whole expected cycle
// sequence (RD/WR/FIN) from the copy rules. It then plays the stimulus.
// A single compare process checks every cycle against that sequence, and
// expects idle outputs when the sequence is empty. Hand-computed literals
// pin the latencies, pulse counts and memory contents.
module tb_mem_copy_dma;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          rst_n, start, abort;
  logic [AW-1:0] src_addr, dst_addr;
  logic [LW-1:0] len;
  logic          busy, done, aborted;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  logic [DW-1:0] mem_wrt_data;
  logic [DW-1:0] mem_rd_data = '0;
`ifdef DMA_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  mem_copy_dma #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wrt_data(mem_wrt_data), .mem_rd_data(mem_rd_data)
`ifdef DMA_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Memory: writes at the rising edge and read data latched while clk is low.
  logic [DW-1:0] mem    [0:4095];
  logic [DW-1:0] refmem [0:4095];
  always @(posedge clk) if (mem_we) mem[mem_addr] = mem_wrt_data;
  always @(negedge clk) if (mem_re) mem_rd_data = mem[mem_addr];

  typedef struct packed {
    logic          busy, re, we, done, aborted;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0;
  bit   chk_en = 0;
  exp_t ce;
  bit   cok;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Per-cycle compare against the expected sequence.
  always @(posedge clk) begin
    #1;
    if (rst_n && chk_en) begin
      ce = (q.size() > 0) ? q.pop_front() : exp_t'('0);
      cok = (busy === ce.busy) && (mem_re === ce.re) && (mem_we === ce.we) &&
            (done === ce.done) && (aborted === ce.aborted) && !(mem_re && mem_we) &&
            (!(ce.re || ce.we) || mem_addr === ce.addr) &&
            (!ce.we || mem_wrt_data === ce.wdata);
      tests++;
      if (!cok) begin
        fails++;
        $display("FAIL cycle t=%0t: got busy=%b re=%b we=%b done=%b ab=%b addr=%h wd=%h, expected busy=%b re=%b we=%b done=%b ab=%b addr=%h wd=%h",
                 $time, busy, mem_re, mem_we, done, aborted, mem_addr, mem_wrt_data,
                 ce.busy, ce.re, ce.we, ce.done, ce.aborted, ce.addr, ce.wdata);
      end
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem[a] = d;
    refmem[a] = d;
  endtask

  // Call this at a negedge while the DUT is idle. abort_k > 0 holds abort
  // high during cycle abort_k after the start edge. For `hold` cycles,
  // start stays high (while busy) with a garbage src.
  task automatic run_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input logic [LW-1:0] n, input int abort_k, input int hold,
                          output int done_k, output int ab_k, output int busy_n,
                          output int wr_n, output int rd_n);
    exp_t e;
    int   total = 0;
    bit   stop = 0;
    logic [DW-1:0] d;
    for (int j = 0; j < int'(n); j++) begin
      e = '0; e.busy = 1; e.re = 1; e.addr = AW'(int'(src) + j);
      q.push_back(e); total++;
      if (abort_k == total) begin stop = 1; break; end
      d = refmem[AW'(int'(src) + j)];
      refmem[AW'(int'(dst) + j)] = d;
      e = '0; e.busy = 1; e.we = 1; e.addr = AW'(int'(dst) + j); e.wdata = d;
      q.push_back(e); total++;
      if (abort_k == total) begin stop = 1; break; end
    end
    e = '0; e.busy = 1; e.done = !stop; e.aborted = stop;
    q.push_back(e); total++;

    src_addr = src; dst_addr = dst; len = n; start = 1;
    done_k = 0; ab_k = 0; busy_n = 0; wr_n = 0; rd_n = 0;
    for (int k = 1; k <= total + 3; k++) begin
      @(negedge clk);
      if (k > hold) start = 0; else src_addr = 12'h007;
      abort = (k == abort_k);
      if (busy) busy_n++;
      if (mem_we) wr_n++;
      if (mem_re) rd_n++;
      if (done && done_k == 0) done_k = k;
      if (aborted && ab_k == 0) ab_k = k;
    end
    start = 0; abort = 0;
  endtask

  int dk, ak, bn, wn, rn, bad;

  initial begin
    rst_n = 0; start = 0; abort = 0; src_addr = '0; dst_addr = '0; len = '0;
    for (int i = 0; i < 4096; i++) poke(AW'(i), 32'hC0DE0000 | i);
    @(negedge clk); @(negedge clk);
    chk("reset outputs", {busy, done, aborted, mem_re, mem_we, mem_addr, mem_wrt_data}, '0);
    rst_n = 1; chk_en = 1;
    @(negedge clk);

    // Basic copy of 4 words; start held for 2 extra cycles while busy is ignored.
    for (int i = 0; i < 4; i++) poke(AW'(12'h010 + i), 32'hA0 + i);
    run_copy(12'h010, 12'h200, 4, 0, 2, dk, ak, bn, wn, rn);
    chk("len4 done cycle", 64'(dk), 9);
    chk("len4 busy cycles", 64'(bn), 9);
    chk("len4 aborted", 64'(ak), 0);
    chk("len4 mem200", mem[12'h200], 32'hA0);
    chk("len4 mem203", mem[12'h203], 32'hA3);

    // Zero length: no memory access at all.
    poke(12'h060, 32'h5A5A);
    run_copy(12'h050, 12'h060, 0, 0, 0, dk, ak, bn, wn, rn);
    chk("len0 done cycle", 64'(dk), 1);
    chk("len0 accesses", 64'(wn + rn), 0);
    chk("len0 mem060", mem[12'h060], 32'h5A5A);

    // Source address wrap.
    poke(12'hFFE, 32'h1111); poke(12'hFFF, 32'h2222);
    poke(12'h000, 32'h3333); poke(12'h001, 32'h4444);
    run_copy(12'hFFE, 12'h100, 4, 0, 0, dk, ak, bn, wn, rn);
    chk("wrap reads", 64'(rn), 4);
    chk("wrap mem101", mem[12'h101], 32'h2222);
    chk("wrap mem102", mem[12'h102], 32'h3333);

    // Abort during the 2nd WR (cycle 4) of a len=8 copy.
    poke(12'h222, 32'hDEAD0222);
    run_copy(12'h020, 12'h220, 8, 4, 0, dk, ak, bn, wn, rn);
    chk("abort writes", 64'(wn), 2);
    chk("abort pulse cycle", 64'(ak), 5);
    chk("abort done", 64'(dk), 0);
    chk("abort busy cycles", 64'(bn), 5);
    chk("abort mem222", mem[12'h222], 32'hDEAD0222);

    // Overlapping forward copy replicates the first word.
    poke(12'h300, 32'h11); poke(12'h301, 32'h22); poke(12'h302, 32'h33); poke(12'h303, 32'h44);
    run_copy(12'h300, 12'h301, 3, 0, 0, dk, ak, bn, wn, rn);
    chk("overlap mem303", mem[12'h303], 32'h11);

`ifdef DMA_CHECKSUM_EN
    poke(12'h500, 32'd1); poke(12'h501, 32'd2); poke(12'h502, 32'd3); poke(12'h503, 32'hFFFFFFFF);
    run_copy(12'h500, 12'h600, 4, 0, 0, dk, ak, bn, wn, rn);
    chk("checksum", checksum, 32'h5);
`endif

    // Reset in the middle of the first RD cycle.
    chk_en = 0;
    poke(12'h400, 32'hBEEF0400);
    src_addr = 12'h010; dst_addr = 12'h400; len = 4; start = 1;
    @(posedge clk); #2;
    chk("rst pre re", 64'(mem_re), 1);
    rst_n = 0; #1;
    chk("rst async re/busy", {mem_re, busy}, 0);
    @(negedge clk); start = 0;
    @(negedge clk); rst_n = 1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || aborted || busy || mem_we) bad++;
    end
    chk("rst no fin", 64'(bad), 0);
    chk("rst mem400", mem[12'h400], 32'hBEEF0400);
    q.delete(); chk_en = 1;
    run_copy(12'h010, 12'h410, 4, 0, 0, dk, ak, bn, wn, rn);
    chk("post-rst done cycle", 64'(dk), 9);
    chk("post-rst mem412", mem[12'h412], 32'hA2);

    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== refmem[i]) bad++;
    chk("mem image", 64'(bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
